// File: rtl/bpsk_demod.sv
// Coherent symbol-synchronous BPSK demodulator: square-wave carrier correlation, sign slicer, MSB-first word packer.
// Optional macro BPSK_DEMOD_SOFT_EN adds the signed correlation output 'soft'.
module bpsk_demod #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic [SAMPLE_WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    data_valid,
  output logic                    busy
`ifdef BPSK_DEMOD_SOFT_EN
  ,
  output logic signed [SAMPLE_WIDTH+$clog2(SAMPLE_NUMBER):0] soft
`endif
);

  localparam int CNT_W = $clog2(SAMPLE_NUMBER);
  localparam int BC_W  = $clog2(DATA_WIDTH);
  localparam int ACC_W = SAMPLE_WIDTH + 1 + CNT_W;

  localparam logic [SAMPLE_WIDTH:0] MID_C    = {2'b01, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_LAST = {CNT_W{1'b1}};
  localparam logic [BC_W-1:0]       BC_ONE   = {{(BC_W-1){1'b0}}, 1'b1};
  localparam logic [BC_W-1:0]       BC_LAST  = BC_W'(DATA_WIDTH-1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [CNT_W-1:0]         sample_cnt_r;
  logic [BC_W-1:0]          bit_cnt_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic [DATA_WIDTH-1:0]    shift_r;
  logic                     bit_out_r;
  logic                     bit_valid_r;
  logic [DATA_WIDTH-1:0]    data_r;
  logic                     data_valid_r;

  logic                     accept_s;
  logic signed [SAMPLE_WIDTH:0] c_s;
  logic signed [ACC_W-1:0]  c_ext_s;
  logic signed [ACC_W-1:0]  term_s;
  logic signed [ACC_W-1:0]  acc_sum_s;
  logic                     last_s;
  logic                     word_end_s;
  logic                     bit_dec_s;
  logic [DATA_WIDTH-1:0]    word_s;

  assign accept_s   = en & din_valid;
  assign c_s        = $signed({1'b0, din}) - $signed(MID_C);
  assign c_ext_s    = {{CNT_W{c_s[SAMPLE_WIDTH]}}, c_s};
  // Negate after widening so that -(-midscale) is representable.
  assign term_s     = sample_cnt_r[CNT_W-1] ? -c_ext_s : c_ext_s;
  assign acc_sum_s  = acc_r + term_s;
  assign last_s     = (sample_cnt_r == CNT_LAST);
  assign word_end_s = (bit_cnt_r == BC_LAST);
  assign bit_dec_s  = ~acc_sum_s[ACC_W-1] & (acc_sum_s != {ACC_W{1'b0}});
  assign word_s     = {shift_r[DATA_WIDTH-2:0], bit_dec_s};

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_s = S_RUN;
        else          state_s = S_IDLE;
      end
      S_RUN: begin
        if (!en) state_s = S_IDLE;
        else     state_s = S_RUN;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Correlator, slicer and word packer; a sync-coincident sample becomes index 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r    <= {BC_W{1'b0}};
      acc_r        <= {ACC_W{1'b0}};
      shift_r      <= {DATA_WIDTH{1'b0}};
      bit_out_r    <= 1'b0;
      bit_valid_r  <= 1'b0;
      data_r       <= {DATA_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
    end else begin
      bit_valid_r  <= 1'b0;
      data_valid_r <= 1'b0;
      if (sync) begin
        bit_cnt_r <= {BC_W{1'b0}};
        shift_r   <= {DATA_WIDTH{1'b0}};
        if (accept_s) begin
          acc_r        <= c_ext_s;
          sample_cnt_r <= CNT_ONE;
        end else begin
          acc_r        <= {ACC_W{1'b0}};
          sample_cnt_r <= {CNT_W{1'b0}};
        end
      end else if (accept_s) begin
        sample_cnt_r <= sample_cnt_r + CNT_ONE;
        if (last_s) begin
          acc_r       <= {ACC_W{1'b0}};
          bit_out_r   <= bit_dec_s;
          bit_valid_r <= 1'b1;
          shift_r     <= word_s;
          if (word_end_s) begin
            bit_cnt_r    <= {BC_W{1'b0}};
            data_r       <= word_s;
            data_valid_r <= 1'b1;
          end else begin
            bit_cnt_r <= bit_cnt_r + BC_ONE;
          end
        end else begin
          acc_r <= acc_sum_s;
        end
      end
    end
  end

`ifdef BPSK_DEMOD_SOFT_EN
  logic signed [ACC_W-1:0] soft_r;

  // Soft value captured alongside the hard decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      soft_r <= {ACC_W{1'b0}};
    end else if (!sync && accept_s && last_s) begin
      soft_r <= acc_sum_s;
    end
  end

  assign soft = soft_r;
`else
  // Hard-decision build: the final correlation only feeds the slicer.
`endif

  assign bit_out    = bit_out_r;
  assign bit_valid  = bit_valid_r;
  assign data       = data_r;
  assign data_valid = data_valid_r;
  assign busy       = (state_r == S_RUN);

endmodule

// File: tb/tb_bpsk_demod.sv
// Directed self-checking bench for bpsk_demod (soft checks active when BPSK_DEMOD_SOFT_EN is defined).
module tb_bpsk_demod;
  localparam int SN = 256;
  localparam logic [11:0] W = 12'hA5C;

  logic        clk = 1'b0;
  logic        rst, en, sync, din_valid;
  logic [11:0] din;
  logic        bit_out, bit_valid, data_valid, busy;
  logic [11:0] data;
`ifdef BPSK_DEMOD_SOFT_EN
  logic signed [20:0] soft;
`endif

  int total = 0;
  int bad   = 0;
  int bv_cnt = 0;
  int dv_cnt = 0;

  bpsk_demod dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .din(din), .din_valid(din_valid),
    .bit_out(bit_out), .bit_valid(bit_valid), .data(data), .data_valid(data_valid),
`ifdef BPSK_DEMOD_SOFT_EN
    .soft(soft),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (bit_valid === 1'b1) bv_cnt++;
    if (data_valid === 1'b1) dv_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic put(input logic [11:0] v, input logic s);
    @(negedge clk);
    en = 1'b1; din = v; din_valid = 1'b1; sync = s;
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0; sync = 1'b0;
  endtask

  // One carrier period; bit 1 puts hi in the first half.
  task automatic send_symbol(input logic b, input logic s, input logic [11:0] hi,
                             input logic [11:0] lo, input int pause_at);
    int b_hold;
    for (int i = 0; i < SN; i++) begin
      if (i == pause_at) begin
        b_hold = bv_cnt;
        for (int j = 0; j < 50; j++) begin
          @(negedge clk);
          en = 1'b0; din_valid = 1'b1; din = 12'd0; sync = 1'b0;
          if (j > 0) begin
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL pause_busy got=%0b exp=0", busy); end
          end
        end
        total++;
        if (bv_cnt != b_hold) begin bad++; $display("FAIL pause_bits got=%0d exp=%0d", bv_cnt, b_hold); end
      end
      put((((i < SN/2) ? 1'b1 : 1'b0) == b) ? hi : lo, s && (i == 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; sync = 1'b0; din_valid = 1'b0; din = 12'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      din = 12'($urandom); din_valid = 1'($urandom); en = 1'($urandom); sync = 1'($urandom);
      total++;
      if ({bit_out, bit_valid, data, data_valid, busy} !== 16'd0) begin
        bad++; $display("FAIL reset_outputs got=%h exp=0", {bit_out, bit_valid, data, data_valid, busy});
      end
    end
    @(negedge clk);
    rst = 1'b1; en = 1'b1; sync = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
    for (int k = 0; k < SN-1; k++) put(12'($urandom), 1'b0);
    idle();
    total++;
    if ({bit_out, bit_valid, data, data_valid} !== 15'd0 || bv_cnt != 0) begin
      bad++; $display("FAIL reset_no_early_output got=%h bits=%0d exp=0", {bit_out, bit_valid, data, data_valid}, bv_cnt);
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy_run got=%0b exp=1", busy); end
  endtask

  task automatic test_single();
    logic b;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0);
      send_symbol(b, 1'b1, 12'd3048, 12'd1048, -1);
      idle();
      total++;
      if (bit_valid !== 1'b1 || bit_out !== b) begin
        bad++; $display("FAIL single_bit got=%0b/%0b exp=1/%0b", bit_valid, bit_out, b);
      end
`ifdef BPSK_DEMOD_SOFT_EN
      total++;
      if (soft !== (b ? 21'sd256000 : -21'sd256000)) begin
        bad++; $display("FAIL single_soft got=%0d exp=%0d", soft, b ? 256000 : -256000);
      end
`endif
      idle();
      total++;
      if (bit_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%0b exp=0", bit_valid); end
    end
  endtask

  task automatic test_word();
    int b0, d0;
    b0 = bv_cnt; d0 = dv_cnt;
    for (int k = 0; k < 12; k++) send_symbol(W[11-k], k == 0, 12'd3048, 12'd1048, -1);
    idle();
    total++;
    if (data_valid !== 1'b1 || bit_valid !== 1'b1 || data !== W) begin
      bad++; $display("FAIL word_data got=%h dv=%0b bv=%0b exp=%h", data, data_valid, bit_valid, W);
    end
    total++;
    if (bv_cnt - b0 != 12 || dv_cnt - d0 != 1) begin
      bad++; $display("FAIL word_counts got=%0d/%0d exp=12/1", bv_cnt - b0, dv_cnt - d0);
    end
    idle();
    total++;
    if (data_valid !== 1'b0 || data !== W) begin
      bad++; $display("FAIL word_clear got=%0b/%h exp=0/%h", data_valid, data, W);
    end
  endtask

  task automatic test_pause();
    int b0, d0;
    b0 = bv_cnt; d0 = dv_cnt;
    for (int k = 0; k < 12; k++) send_symbol(W[11-k], k == 0, 12'd3048, 12'd1048, (k == 0) ? 100 : -1);
    idle();
    total++;
    if (data_valid !== 1'b1 || data !== W) begin
      bad++; $display("FAIL pause_word got=%h dv=%0b exp=%h", data, data_valid, W);
    end
    total++;
    if (bv_cnt - b0 != 12 || dv_cnt - d0 != 1) begin
      bad++; $display("FAIL pause_counts got=%0d/%0d exp=12/1", bv_cnt - b0, dv_cnt - d0);
    end
  endtask

  task automatic test_realign();
    int b0, b1, d0;
    b0 = bv_cnt; d0 = dv_cnt;
    send_symbol(1'b1, 1'b1, 12'd3048, 12'd1048, -1);
    for (int i = 0; i < 60; i++) put(12'd1048, 1'b0);
    b1 = bv_cnt;
    total++;
    if (b1 - b0 != 1) begin bad++; $display("FAIL realign_partial got=%0d exp=1", b1 - b0); end
    for (int k = 0; k < 12; k++) send_symbol(W[11-k], k == 0, 12'd3048, 12'd1048, -1);
    idle();
    total++;
    if (data_valid !== 1'b1 || data !== W) begin
      bad++; $display("FAIL realign_word got=%h dv=%0b exp=%h", data, data_valid, W);
    end
    total++;
    if (bv_cnt - b1 != 12 || dv_cnt - d0 != 1) begin
      bad++; $display("FAIL realign_counts got=%0d/%0d exp=12/1", bv_cnt - b1, dv_cnt - d0);
    end
  endtask

  task automatic test_edges();
    int d0;
    send_symbol(1'b1, 1'b1, 12'd3048, 12'd1048, -1);
    send_symbol(1'b1, 1'b0, 12'd2048, 12'd2048, -1);
    idle();
    total++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b0) begin
      bad++; $display("FAIL edge_midscale got=%0b/%0b exp=1/0", bit_valid, bit_out);
    end
`ifdef BPSK_DEMOD_SOFT_EN
    total++;
    if (soft !== 21'sd0) begin bad++; $display("FAIL edge_midscale_soft got=%0d exp=0", soft); end
`endif
    // 128*2047 + 128*2048 = 524160
    send_symbol(1'b1, 1'b0, 12'd4095, 12'd0, -1);
    idle();
    total++;
    if (bit_out !== 1'b1) begin bad++; $display("FAIL edge_fullscale_pos got=%0b exp=1", bit_out); end
`ifdef BPSK_DEMOD_SOFT_EN
    total++;
    if (soft !== 21'sd524160) begin bad++; $display("FAIL edge_fullscale_soft got=%0d exp=524160", soft); end
`endif
    send_symbol(1'b0, 1'b0, 12'd4095, 12'd0, -1);
    idle();
    total++;
    if (bit_out !== 1'b0) begin bad++; $display("FAIL edge_fullscale_neg got=%0b exp=0", bit_out); end
`ifdef BPSK_DEMOD_SOFT_EN
    total++;
    if (soft !== -21'sd524160) begin bad++; $display("FAIL edge_fullscale_nsoft got=%0d exp=-524160", soft); end
`endif
    // Reset in the middle of a word, then a full word with no sync.
    for (int k = 0; k < 5; k++) send_symbol(1'b1, k == 0, 12'd3048, 12'd1048, -1);
    for (int i = 0; i < 30; i++) put(12'd3048, 1'b0);
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bit_out, bit_valid, data, data_valid, busy} !== 16'd0) begin
      bad++; $display("FAIL edge_reset_outputs got=%h exp=0", {bit_out, bit_valid, data, data_valid, busy});
    end
    rst = 1'b1;
    d0 = dv_cnt;
    for (int k = 0; k < 7; k++) send_symbol(W[11-k], 1'b0, 12'd3048, 12'd1048, -1);
    idle();
    total++;
    if (dv_cnt != d0 || data !== 12'h000) begin
      bad++; $display("FAIL edge_reset_partial got=%0d/%h exp=0/000", dv_cnt - d0, data);
    end
    for (int k = 7; k < 12; k++) send_symbol(W[11-k], 1'b0, 12'd3048, 12'd1048, -1);
    idle();
    total++;
    if (data_valid !== 1'b1 || data !== W || dv_cnt - d0 != 1) begin
      bad++; $display("FAIL edge_reset_word got=%h dv=%0b n=%0d exp=%h", data, data_valid, dv_cnt - d0, W);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; sync = 1'b0; din_valid = 1'b0; din = 12'd0;
    test_reset();
    test_single();
    test_word();
    test_pause();
    test_realign();
    test_edges();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
